// File: rtl/iterative_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shared shift-add / restoring-divide
// datapath over magnitudes, sign fix-up in a final cycle, results in HI/LO.
module iterative_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic [WIDTH-1:0] hi_output,
    output logic [WIDTH-1:0] lo_output,
    output logic             stall,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;

    logic               is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_res, neg_rem;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               load, step, fix;

    // operand decode at acceptance
    logic             signed_op, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_abs, b_abs;
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & input_1[WIDTH-1];
        b_neg     = signed_op & input_2[WIDTH-1];
        div_zero  = op[1] & (input_2 == '0);
        // divide-by-zero keeps the raw dividend so it emerges unchanged as the remainder
        a_abs     = (a_neg && !div_zero) ? -input_1 : input_1;
        b_abs     = b_neg ? -input_2 : input_2;
    end

    // one iteration of either algorithm over the shared accumulator
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag};
        div_ge    = ~div_trial[WIDTH];
        div_next  = {div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0],
                     acc[WIDTH-2:0], div_ge};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        load = (state == IDLE) && start;
        step = (state == RUN);
        fix  = (state == FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_div    <= 1'b0;
            a_mag     <= '0;
            b_mag     <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            hi_output <= '0;
            lo_output <= '0;
            stall     <= 1'b0;
            done      <= 1'b0;
        end else begin
            stall <= (state_n != IDLE);
            done  <= fix;
            if (load) begin
                is_div  <= op[1];
                a_mag   <= a_abs;
                b_mag   <= b_abs;
                neg_res <= (a_neg ^ b_neg) & ~div_zero;
                neg_rem <= a_neg & op[1] & ~div_zero;
                acc     <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
                cnt     <= '0;
            end
            if (step) begin
                acc <= is_div ? div_next : mul_next;
                cnt <= cnt + CW'(1);
            end
            if (fix) begin
                hi_output <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_output <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Scoreboard bench for iterative_muldiv_unit: expectations queued at issue,
// compared against HI/LO whenever done pulses.
module tb_iterative_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] input_1, input_2, hi_output, lo_output;
    logic         stall, done;

    int vectors = 0;
    int miscompares = 0;
    logic [2*W-1:0] sb[$];

    iterative_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .input_1(input_1), .input_2(input_2),
        .hi_output(hi_output), .lo_output(lo_output),
        .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: res = sa * sb2;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb2;
                    r = sa % sb2;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else res = {(a % b), (a / b)};
            end
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("spurious_done", {63'b0, done}, 64'd0);
            else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("hi", {32'b0, hi_output}, {32'b0, e[63:32]});
                chk("lo", {32'b0, lo_output}, {32'b0, e[31:0]});
            end
        end
    end

    // called at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op = o; input_1 = a; input_2 = b; start = 1'b1;
        if (push) sb.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
        input_1 = $urandom; input_2 = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input int pre);
        int n;
        n = pre;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", 64'(n), 64'd33);
        chk("done_set", {63'b0, done}, 64'd1);
        @(negedge clk);
        chk("done_pulse", {63'b0, done}, 64'd0);
    endtask

    logic [1:0]  t_op[9] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] t_a[9]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7,
                             32'd7, 32'h80000000, 32'd5, 32'hFFFFFFFB};
    logic [31:0] t_b[9]  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] corner[6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd13};

    initial begin
        int n;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; op = 2'b00; input_1 = '0; input_2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", {32'b0, hi_output}, 64'd0);
        chk("rst_lo", {32'b0, lo_output}, 64'd0);
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // spot values from the table, including overflow and divide by zero
        for (int i = 0; i < 9; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 1'b1);
            wait_done(0);
        end
        chk("hold_hi", {32'b0, hi_output}, 64'h00000000FFFFFFFB);

        // randomised ops over corner operands
        for (int i = 0; i < 12; i++) begin
            a = (i % 2 == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = (i % 3 == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            issue(2'($urandom_range(0, 3)), a, b, 1'b1);
            wait_done(0);
        end

        // start while busy is ignored
        issue(2'b00, 32'd6, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        op = 2'b11; input_1 = 32'd100; input_2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5);
        repeat (40) @(negedge clk);
        chk("busy_ignored_stall", {63'b0, stall}, 64'd0);

        // reset aborts an operation in flight; old result visible until then
        issue(2'b10, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        chk("run_hold_lo", {32'b0, lo_output}, 64'd42);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_stall", {63'b0, stall}, 64'd0);
        chk("abort_hi", {32'b0, hi_output}, 64'd0);
        chk("abort_lo", {32'b0, lo_output}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle", {63'b0, stall}, 64'd0);

        // start held high across two back-to-back operations
        op = 2'b01; input_1 = 32'd3; input_2 = 32'd4; start = 1'b1;
        sb.push_back(model(2'b01, 32'd3, 32'd4));
        @(negedge clk);
        n = 1;
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("held_latency", 64'(n), 64'd34);
        op = 2'b11; input_1 = 32'd9; input_2 = 32'd4;
        sb.push_back(model(2'b11, 32'd9, 32'd4));
        @(negedge clk);
        chk("held_accept", {63'b0, stall}, 64'd1);
        start = 1'b0; input_1 = 32'hDEADBEEF; input_2 = 32'd1;
        wait_done(0);
        chk("held_lo", {32'b0, lo_output}, 64'd2);
        chk("held_hi", {32'b0, hi_output}, 64'd1);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
